// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches 16-bit words over req/rvalid, presents OPCODE/flagbit/IMM.
// Define FETCH_PREFETCH_EN to replace the single IR with a 2-entry prefetch FIFO.
module instr_fetch_unit #(
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
   input  logic          CLK,
   input  logic          RST_N,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_rvalid,
   input  logic [15:0]   imem_rdata,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [4:0]    OPCODE,
   output logic          flagbit,
   output logic [9:0]    IMM,
   output logic [AW-1:0] pc_of_instr,
   input  logic          redirect_en,
   input  logic [AW-1:0] redirect_pc
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t        state, state_n;
   logic [AW-1:0] pc, pc_n;
   logic          squash, squash_n;
   logic          take;
   logic [15:0]   head_ir;
   logic [AW-1:0] head_pc;

`ifdef FETCH_PREFETCH_EN
   logic [1:0]           cnt;
   logic [1:0][15:0]     fifo_ir;
   logic [1:0][AW-1:0]   fifo_pc;
   logic                 pop;
   logic                 wr_slot;
`endif

   // imem_addr holds the squashed request's address until its response drains
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         squash    <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         squash    <= squash_n;
         imem_addr <= squash_n ? imem_addr : pc_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      squash_n = squash;
      take     = 1'b0;
      unique case (state)
         IDLE:  state_n = FETCH;
         FETCH: begin
            if (imem_rvalid) begin
               if (squash) squash_n = 1'b0;
               else begin
                  take = 1'b1;
                  pc_n = pc + AW'(2);
`ifndef FETCH_PREFETCH_EN
                  state_n = HOLD;
`endif
               end
            end
         end
         HOLD:    if (instr_ready) state_n = FETCH;
         default: state_n = IDLE;
      endcase
      // Redirect wins; a same-cycle response is simply dropped
      if (redirect_en) begin
         pc_n     = redirect_pc & ~AW'(1);
         state_n  = FETCH;
         take     = 1'b0;
         squash_n = imem_req && !imem_rvalid;
      end
   end

   always_comb begin
`ifdef FETCH_PREFETCH_EN
      imem_req    = (state == FETCH) && (cnt != 2'd2);
      instr_valid = (cnt != 2'd0);
`else
      imem_req    = (state == FETCH);
      instr_valid = (state == HOLD);
`endif
   end

`ifdef FETCH_PREFETCH_EN
   assign pop     = instr_valid && instr_ready;
   assign wr_slot = (cnt == 2'd2) || ((cnt == 2'd1) && !pop);

   // Slot 0 is the head; a pop shifts slot 1 down, a push lands behind the survivors
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt     <= 2'd0;
         fifo_ir <= '0;
         fifo_pc <= {2{RESET_PC}};
      end else if (redirect_en) begin
         cnt <= 2'd0;
      end else begin
         if (pop) begin
            fifo_ir[0] <= fifo_ir[1];
            fifo_pc[0] <= fifo_pc[1];
         end
         if (take) begin
            fifo_ir[wr_slot] <= imem_rdata;
            fifo_pc[wr_slot] <= pc;
         end
         cnt <= cnt + 2'(take) - 2'(pop);
      end
   end

   assign head_ir = fifo_ir[0];
   assign head_pc = fifo_pc[0];
`else
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         head_ir <= 16'h0000;
         head_pc <= RESET_PC;
      end else if (take) begin
         head_ir <= imem_rdata;
         head_pc <= pc;
      end
   end
`endif

   assign OPCODE      = head_ir[15:11];
   assign flagbit     = head_ir[10];
   assign IMM         = head_ir[9:0];
   assign pc_of_instr = head_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: 1-cycle memory model plus an expected-instruction scoreboard.
module tb_instr_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  OPCODE;
   logic        flagbit;
   logic [9:0]  IMM;
   logic [15:0] pc_of_instr;
   logic        redirect_en;
   logic [15:0] redirect_pc;

   logic        mem_en, mem_rvalid, man_rvalid;
   logic [15:0] mem_rdata, man_rdata;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] w;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_chk  = 0;
   int   n_fail = 0;

   instr_fetch_unit #(.AW(16), .RESET_PC(16'h0000)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .OPCODE(OPCODE), .flagbit(flagbit), .IMM(IMM),
      .pc_of_instr(pc_of_instr),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a == 16'h0000) ? 16'h0805 : (a * 16'd3 + 16'h1234);
   endfunction

   // Memory answers one cycle after it sees a request; manual drive overrides it when mem_en=0
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mem_rvalid <= 1'b0;
         mem_rdata  <= 16'h0000;
      end else if (mem_en && imem_req && !mem_rvalid) begin
         mem_rvalid <= 1'b1;
         mem_rdata  <= mem_word(imem_addr);
      end else begin
         mem_rvalid <= 1'b0;
      end
   end

   assign imem_rvalid = mem_en ? mem_rvalid : man_rvalid;
   assign imem_rdata  = mem_en ? mem_rdata  : man_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [15:0] a);
      exp_t e;
      e.pc = a;
      e.w  = mem_word(a);
      exp_q.push_back(e);
   endtask

   task automatic wait_instr();
      int n = 0;
      while (instr_valid !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("instr_valid_wait", 32'(instr_valid), 32'd1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         cur = exp_q.pop_front();
         chk("opcode",      32'(OPCODE),      32'(cur.w[15:11]));
         chk("flagbit",     32'(flagbit),     32'(cur.w[10]));
         chk("imm",         32'(IMM),         32'(cur.w[9:0]));
         chk("pc_of_instr", 32'(pc_of_instr), 32'(cur.pc));
      end
   endtask

   task automatic accept();
      instr_ready = 1'b1;
      @(negedge CLK);
      instr_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N       = 1'b0;
      instr_ready = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 16'h0000;
      mem_en      = 1'b1;
      man_rvalid  = 1'b0;
      man_rdata   = 16'h0000;
      repeat (3) @(negedge CLK);

      chk("rst_req",     32'(imem_req),    32'd0);
      chk("rst_addr",    32'(imem_addr),   32'h0000);
      chk("rst_valid",   32'(instr_valid), 32'd0);
      chk("rst_opcode",  32'(OPCODE),      32'd0);
      chk("rst_flagbit", 32'(flagbit),     32'd0);
      chk("rst_imm",     32'(IMM),         32'd0);
      chk("rst_pc",      32'(pc_of_instr), 32'h0000);

      // Startup: one idle cycle, then fetch from RESET_PC
      RST_N = 1'b1;
      chk("idle_req", 32'(imem_req), 32'd0);
      @(negedge CLK);
      chk("first_req",  32'(imem_req),  32'd1);
      chk("first_addr", 32'(imem_addr), 32'h0000);
      push_exp(16'h0000);
      wait_instr();
      chk("first_opcode", 32'(OPCODE), 32'h01);
      chk("first_imm",    32'(IMM),    32'h005);

      // Stall: outputs hold, no further fetch
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("hold_valid",  32'(instr_valid), 32'd1);
         chk("hold_req",    32'(imem_req),    32'd0);
         chk("hold_opcode", 32'(OPCODE),      32'(cur.w[15:11]));
         chk("hold_pc",     32'(pc_of_instr), 32'(cur.pc));
      end
      accept();
      chk("next_req",  32'(imem_req),  32'd1);
      chk("next_addr", 32'(imem_addr), 32'h0002);
      push_exp(16'h0002);
      wait_instr();

      // Redirect while fetch to 4 is outstanding
      accept();
      chk("out_req",  32'(imem_req),  32'd1);
      chk("out_addr", 32'(imem_addr), 32'h0004);
      redirect_en = 1'b1;
      redirect_pc = 16'h0041;
      @(negedge CLK);
      redirect_en = 1'b0;
      chk("squash_req",   32'(imem_req),    32'd1);
      chk("squash_addr",  32'(imem_addr),   32'h0004);
      chk("squash_valid", 32'(instr_valid), 32'd0);
      @(negedge CLK);
      chk("redir_req",   32'(imem_req),    32'd1);
      chk("redir_addr",  32'(imem_addr),   32'h0040);
      chk("redir_valid", 32'(instr_valid), 32'd0);
      push_exp(16'h0040);
      wait_instr();

      // Redirect together with acceptance, to the top of the address space
      instr_ready = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 16'hFFFE;
      @(negedge CLK);
      instr_ready = 1'b0;
      redirect_en = 1'b0;
      chk("top_req",   32'(imem_req),    32'd1);
      chk("top_addr",  32'(imem_addr),   32'hFFFE);
      chk("top_valid", 32'(instr_valid), 32'd0);
      push_exp(16'hFFFE);
      wait_instr();
      accept();
      chk("wrap_req",  32'(imem_req),  32'd1);
      chk("wrap_addr", 32'(imem_addr), 32'h0000);

      // Reset mid-fetch; a late response after release must be ignored
      mem_en = 1'b0;
      #1 RST_N = 1'b0;
      #1;
      chk("midrst_req",   32'(imem_req),    32'd0);
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      @(negedge CLK);
      RST_N      = 1'b1;
      man_rvalid = 1'b1;
      man_rdata  = 16'hFFFF;
      @(negedge CLK);
      man_rvalid = 1'b0;
      chk("late_valid", 32'(instr_valid), 32'd0);
      chk("late_req",   32'(imem_req),    32'd1);
      chk("late_addr",  32'(imem_addr),   32'h0000);
      mem_en = 1'b1;
      push_exp(16'h0000);
      wait_instr();
      accept();
      chk("restart_addr", 32'(imem_addr), 32'h0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
